// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: watches a multiplexed active-high 7-segment bus and
// recovers the hex nibble shown on each digit. A digit is captured once its
// {an,seg} pattern has been stable long enough; a frame is published once
// every digit has been captured, or dropped after a long quiet spell.
//
// Output handshake: frame_valid and timeout are one-cycle strobes with no
// ready/backpressure. value/digit_err change only in the cycle frame_valid
// is high and hold their contents otherwise.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS  = 4,
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_valid,
    output logic                    timeout,
    output logic [1:0]              fsm_state
);

    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYC);
    localparam logic [CW-1:0] CNT_HIT  = CW'(STABLE_CYC - 1);
    localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] IDLE_HIT = TW'(TIMEOUT_CYC - 1);
    localparam logic [NUM_DIGITS-1:0] ALL_SEEN = {NUM_DIGITS{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [6:0]              seg_s1, seg_s2;
    logic [NUM_DIGITS-1:0]   an_s1, an_s2;
    logic [CW-1:0]           cnt;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [NUM_DIGITS-1:0]   err_sh;
    logic [NUM_DIGITS-1:0]   seen;
    logic [TW-1:0]           idle_cnt;

    logic                    change_next;
    logic                    one_hot;
    logic                    capture;
    logic [NUM_DIGITS-1:0]   cap_mask;
    logic [3:0]              dec_nib;
    logic                    dec_bad;
    logic                    all_seen_nx;
    logic                    drop;
    logic                    publish;

    // Exact-match glyph lookup; anything that is not a hex glyph decodes to 0 and is flagged.
    function automatic logic [4:0] decode_glyph(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1111110: r = 5'h00;
            7'b0110000: r = 5'h01;
            7'b1101101: r = 5'h02;
            7'b1111001: r = 5'h03;
            7'b0110011: r = 5'h04;
            7'b1011011: r = 5'h05;
            7'b1011111: r = 5'h06;
            7'b1110000: r = 5'h07;
            7'b1111111: r = 5'h08;
            7'b1111011: r = 5'h09;
            7'b1110111: r = 5'h0A;
            7'b0011111: r = 5'h0B;
            7'b1001110: r = 5'h0C;
            7'b0111101: r = 5'h0D;
            7'b1001111: r = 5'h0E;
            7'b1000111: r = 5'h0F;
            default:    r = 5'h10;
        endcase
        return r;
    endfunction

    // Two-flop synchroniser for the asynchronous display bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1 <= '0;
            seg_s2 <= '0;
            an_s1  <= '0;
            an_s2  <= '0;
        end else begin
            seg_s1 <= seg_in;
            seg_s2 <= seg_s1;
            an_s1  <= an_in;
            an_s2  <= an_s1;
        end
    end

    // Stability detect and capture qualification on the synchronised copy.
    // change_next compares the value about to enter seg_s2/an_s2 with the
    // current one, so cnt tracks how long the synced pattern has held.
    always_comb begin
        change_next = ({an_s1, seg_s1} != {an_s2, seg_s2});
        one_hot     = (an_s2 != '0) && ((an_s2 & (an_s2 - NUM_DIGITS'(1))) == '0);
        capture     = !change_next && (cnt == CNT_HIT) && one_hot;
        cap_mask    = capture ? an_s2 : '0;
        {dec_bad, dec_nib} = decode_glyph(seg_s2);
    end

    // Stability counter: clears on any change, saturates so each stable period captures once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (change_next) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (capture) begin
                    state_nx = (cap_mask == ALL_SEEN) ? PUBLISH : COLLECT;
                end
            end
            COLLECT: begin
                if (all_seen_nx) begin
                    state_nx = PUBLISH;
                end else if (drop) begin
                    state_nx = IDLE;
                end
            end
            PUBLISH: state_nx = COLLECT;
            default: state_nx = IDLE;
        endcase
    end

    // FSM output decode: publish strobe, partial-frame drop, debug state.
    always_comb begin
        all_seen_nx = ((seen | cap_mask) == ALL_SEEN);
        drop        = (state == COLLECT) && !capture && (idle_cnt == IDLE_HIT);
        publish     = (state == PUBLISH);
        fsm_state   = state;
    end

    // Frame datapath: shadow capture, seen tracking, idle timer and published outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow      <= '0;
            err_sh      <= '0;
            seen        <= '0;
            idle_cnt    <= '0;
            value       <= '0;
            digit_err   <= '0;
            frame_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            frame_valid <= publish;
            timeout     <= drop;

            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (cap_mask[k]) begin
                    shadow[4*k +: 4] <= dec_nib;
                    err_sh[k]        <= dec_bad;
                end
            end

            case (state)
                COLLECT: seen <= drop ? '0 : (seen | cap_mask);
                default: seen <= cap_mask;
            endcase

            if (capture || drop || (state == IDLE)) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + TW'(1);
            end

            if (publish) begin
                value     <= shadow;
                digit_err <= err_sh;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Testbench for seg7_scan_decoder: directed scenarios plus randomized scan
// traffic, checked every cycle against a timeline model of captures/frames.
module tb_seg7_scan_decoder;

    localparam int ND = 4;
    localparam int S  = 4;
    localparam int T  = 256;
    localparam logic [1:0] ST_IDLE = 2'd0;

    logic          clk;
    logic          rst_n;
    logic [6:0]    seg_in;
    logic [ND-1:0] an_in;
    logic [4*ND-1:0] value;
    logic [ND-1:0] digit_err;
    logic          frame_valid;
    logic          timeout;
    logic [1:0]    fsm_state;

    seg7_scan_decoder #(
        .NUM_DIGITS (ND),
        .STABLE_CYC (S),
        .TIMEOUT_CYC(T)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .an_in      (an_in),
        .value      (value),
        .digit_err  (digit_err),
        .frame_valid(frame_valid),
        .timeout    (timeout),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [6:0] glyph [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    typedef struct {
        int         t;
        logic [3:0] an;
        logic [6:0] seg;
    } cap_t;

    cap_t        cap_q[$];
    logic [19:0] exp_q[$];
    int          exp_t_q[$];

    logic [15:0] m_shadow;
    logic [3:0]  m_errs;
    logic [3:0]  m_seen;
    logic [15:0] model_value;
    logic [3:0]  model_err;
    bit          active;
    int          last_cap;
    int          fv_cnt = 0;
    int          to_cnt = 0;

    // The display bus is captured STABLE_CYC+2 edges after a change, provided the
    // pattern is held at least STABLE_CYC+1 cycles; the model reasons in those terms.
    always @(negedge clk) begin
        logic       exp_fv;
        logic       exp_to;
        logic [19:0] w;
        cap_t       c;
        int         k;
        logic [3:0] nib;
        logic       bad;
        if (!rst_n) begin
            cap_q.delete();
            exp_q.delete();
            exp_t_q.delete();
            m_shadow = '0; m_errs = '0; m_seen = '0;
            model_value = '0; model_err = '0;
            active = 0; last_cap = 0;
        end else begin
            exp_fv = 1'b0;
            exp_to = 1'b0;
            if (exp_t_q.size() > 0 && exp_t_q[0] == cyc) begin
                exp_fv = 1'b1;
                w = exp_q.pop_front();
                void'(exp_t_q.pop_front());
                model_value = w[15:0];
                model_err   = w[19:16];
            end
            while (cap_q.size() > 0 && cap_q[0].t <= cyc) begin
                c = cap_q.pop_front();
                if (c.t == cyc) begin
                    k = 0;
                    for (int i = 0; i < ND; i++) if (c.an[i]) k = i;
                    nib = 4'h0; bad = 1'b1;
                    for (int i = 0; i < 16; i++) begin
                        if (glyph[i] == c.seg) begin nib = 4'(i); bad = 1'b0; end
                    end
                    if (!active) begin active = 1; m_seen = '0; end
                    m_seen[k] = 1'b1;
                    m_shadow[4*k +: 4] = nib;
                    m_errs[k] = bad;
                    last_cap = cyc;
                    if (m_seen == 4'hF) begin
                        exp_q.push_back({m_errs, m_shadow});
                        exp_t_q.push_back(cyc + 1);
                        m_seen = '0;
                    end
                end
            end
            if (active && cyc == last_cap + T) begin
                exp_to = 1'b1;
                active = 0;
                m_seen = '0;
            end
            check("frame_valid", 32'(frame_valid), 32'(exp_fv));
            check("timeout", 32'(timeout), 32'(exp_to));
            check("value", 32'(value), 32'(model_value));
            check("digit_err", 32'(digit_err), 32'(model_err));
            check("idle_state", 32'(fsm_state == ST_IDLE), 32'(!active));
            if (frame_valid) fv_cnt++;
            if (timeout) to_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    logic [10:0] prev_pins = '0;

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int hold);
        cap_t c;
        @(negedge clk);
        if ({a, s} == prev_pins) s = s ^ 7'b0000001;
        an_in  = a;
        seg_in = s;
        prev_pins = {a, s};
        if (hold >= S + 1 && $countones(a) == 1) begin
            c.t = cyc + 2 + S;
            c.an = a;
            c.seg = s;
            cap_q.push_back(c);
        end
        repeat (hold - 1) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        an_in  = '0;
        seg_in = '0;
        prev_pins = '0;
        repeat (3) @(negedge clk);
        check("rst_value", 32'(value), 32'h0);
        check("rst_digit_err", 32'(digit_err), 32'h0);
        check("rst_pulses", 32'({frame_valid, timeout}), 32'h0);
        check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int fv0;
        int to0;
        int hold_tab[7] = '{1, 2, S, S + 1, S + 2, 8, 12};
        logic [3:0] a;
        logic [6:0] s;
        int h;

        rst_n  = 1'b0;
        an_in  = '0;
        seg_in = '0;

        // 1: clean scan of 1,2,3,4
        do_reset();
        fv0 = fv_cnt;
        for (int d = 0; d < 4; d++) drive(4'(1 << d), glyph[d + 1], 8);
        idle_cycles(10);
        check("t1_frames", 32'(fv_cnt - fv0), 32'd1);
        check("t1_value", 32'(value), 32'h4321);
        check("t1_err", 32'(digit_err), 32'h0);

        // 2: illegal glyph on digit 2
        do_reset();
        fv0 = fv_cnt;
        drive(4'b0001, glyph[1], 8);
        drive(4'b0010, glyph[2], 8);
        drive(4'b0100, 7'b1010101, 8);
        drive(4'b1000, glyph[4], 8);
        idle_cycles(10);
        check("t2_frames", 32'(fv_cnt - fv0), 32'd1);
        check("t2_value", 32'(value), 32'h4021);
        check("t2_err", 32'(digit_err), 32'b0100);

        // 3: glitching digit 0 then a stable 7
        do_reset();
        fv0 = fv_cnt;
        for (int i = 0; i < 20; i++) drive(4'b0001, (i % 2 == 0) ? glyph[7] : 7'b0000000, 1);
        check("t3_no_capture", 32'(fsm_state), 32'(ST_IDLE));
        drive(4'b0001, glyph[7], 8);
        for (int d = 1; d < 4; d++) drive(4'(1 << d), glyph[d], 8);
        idle_cycles(10);
        check("t3_frames", 32'(fv_cnt - fv0), 32'd1);
        check("t3_value", 32'(value), 32'h3217);

        // 4: multi-hot and zero selects are ignored
        do_reset();
        fv0 = fv_cnt;
        drive(4'b0011, glyph[5], 50);
        drive(4'b0000, glyph[6], 50);
        check("t4_frames", 32'(fv_cnt - fv0), 32'd0);
        check("t4_state", 32'(fsm_state), 32'(ST_IDLE));

        // 5: partial frame times out, value untouched
        do_reset();
        for (int d = 0; d < 4; d++) drive(4'(1 << d), glyph[d + 1], 8);
        to0 = to_cnt;
        drive(4'b0001, glyph[5], 8);
        drive(4'b0010, glyph[6], T + 30);
        check("t5_timeouts", 32'(to_cnt - to0), 32'd1);
        check("t5_value", 32'(value), 32'h4321);
        check("t5_state", 32'(fsm_state), 32'(ST_IDLE));

        // 6: reset mid-frame, then a fresh A,b,C,d scan
        do_reset();
        drive(4'b0001, glyph[9], 8);
        drive(4'b0010, glyph[8], 8);
        do_reset();
        fv0 = fv_cnt;
        for (int d = 0; d < 4; d++) drive(4'(1 << d), glyph[10 + d], 8);
        idle_cycles(10);
        check("t6_frames", 32'(fv_cnt - fv0), 32'd1);
        check("t6_value", 32'(value), 32'hDCBA);
        check("t6_err", 32'(digit_err), 32'h0);

        // randomized scan traffic, including glitches, illegal glyphs and idles
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 8) a = 4'(1 << $urandom_range(0, 3));
            else a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) < 8) s = glyph[$urandom_range(0, 15)];
            else s = 7'($urandom_range(0, 127));
            h = hold_tab[$urandom_range(0, 6)];
            if (i % 150 == 149) h = T + 20;
            drive(a, s, h);
        end
        idle_cycles(T + 20);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
